// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern constants, bit order and readback types
package seg7_pkg;

  localparam int SEG_W   = 7;
  localparam int FRAME_W = 3 * SEG_W + 3;

  // Segment bit order inside a pattern: bit0 = a ... bit6 = g, active-low.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } rb_state_t;

endpackage

// File: rtl/seg7_to_digit.sv
// rtl/seg7_to_digit.sv - combinational decode of one active-low segment pattern to a BCD digit
module seg7_to_digit
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       digit,
  output logic             legal,
  output logic             blank
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    blank = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      // A dark digit is a leading-zero suppression, so it reads back as 0.
      SEG_BLANK: blank = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_readback_decoder.sv
// rtl/seg_readback_decoder.sv - debounced readback of a three-digit seven-segment display
module seg_readback_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEG_W-1:0] seg1,
  input  logic [SEG_W-1:0] seg2,
  input  logic [SEG_W-1:0] seg3,
  input  logic             seg1_dpt,
  input  logic             seg2_dpt,
  input  logic             seg3_dpt,
  output logic [9:0]       value,
  output logic [2:0]       dp,
  output logic             valid,
  output logic             err
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  rb_state_t          state, state_d;
  logic [FRAME_W-1:0] frame, snap, snap_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [9:0]         value_d;
  logic [2:0]         dp_d;
  logic               valid_d, err_d;

  logic [3:0] dig_h, dig_t, dig_o;
  logic [2:0] legal;
  logic [2:0] unused_blank;

  assign frame = {seg1, seg2, seg3, seg1_dpt, seg2_dpt, seg3_dpt};

  // Decode from snap: when a report fires the live frame equals snap anyway.
  seg7_to_digit u_dec_h (
    .pattern (snap[FRAME_W-1 -: SEG_W]),
    .digit   (dig_h),
    .legal   (legal[2]),
    .blank   (unused_blank[2])
  );

  seg7_to_digit u_dec_t (
    .pattern (snap[FRAME_W-1-SEG_W -: SEG_W]),
    .digit   (dig_t),
    .legal   (legal[1]),
    .blank   (unused_blank[1])
  );

  seg7_to_digit u_dec_o (
    .pattern (snap[FRAME_W-1-2*SEG_W -: SEG_W]),
    .digit   (dig_o),
    .legal   (legal[0]),
    .blank   (unused_blank[0])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SETTLE;
      snap  <= '1;
      cnt   <= '0;
      value <= '0;
      dp    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      snap  <= snap_d;
      cnt   <= cnt_d;
      value <= value_d;
      dp    <= dp_d;
      valid <= valid_d;
      err   <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    snap_d  = snap;
    cnt_d   = cnt;
    value_d = value;
    dp_d    = dp;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (en) begin
      // A change restarts settling even on the cycle a report would fire.
      if (frame != snap) begin
        snap_d  = frame;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end else if (state == ST_SETTLE) begin
        if (cnt == CNT_LAST) begin
          state_d = ST_HOLD;
          if (&legal) begin
            value_d = 10'(dig_h) * 10'd100 + 10'(dig_t) * 10'd10 + 10'(dig_o);
            dp_d    = ~snap[2:0];
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_readback_decoder.sv
// tb/tb_seg_readback_decoder.sv - directed and randomized check of seg_readback_decoder
module tb_seg_readback_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [6:0] seg1 = 7'h7f, seg2 = 7'h7f, seg3 = 7'h7f;
  logic       seg1_dpt = 1'b1, seg2_dpt = 1'b1, seg3_dpt = 1'b1;
  logic [9:0] value;
  logic [2:0] dp;
  logic       valid, err;

  int errors = 0;
  int checks = 0;

  // Legal glyphs indexed by the digit they show.
  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference: last sampled frame, how many enabled samples it has stayed put, whether reported.
  logic [23:0] m_frame;
  int          m_run;
  bit          m_reported;
  logic [9:0]  exp_value;
  logic [2:0]  exp_dp;
  logic        exp_valid, exp_err;

  seg_readback_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3),
    .seg1_dpt (seg1_dpt),
    .seg2_dpt (seg2_dpt),
    .seg3_dpt (seg3_dpt),
    .value    (value),
    .dp       (dp),
    .valid    (valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic int digit_of(input logic [6:0] p);
    if (p == 7'b1111111) return 0;
    for (int i = 0; i < 10; i++)
      if (glyph[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    int h, t, o;
    if (rst) begin
      m_frame = '1; m_run = 0; m_reported = 0;
      exp_value = 0; exp_dp = 0; exp_valid = 0; exp_err = 0;
    end else begin
      exp_valid = 0;
      exp_err   = 0;
      if (en) begin
        if ({seg1, seg2, seg3, seg1_dpt, seg2_dpt, seg3_dpt} != m_frame) begin
          m_frame = {seg1, seg2, seg3, seg1_dpt, seg2_dpt, seg3_dpt};
          m_run = 0;
          m_reported = 0;
        end else if (!m_reported) begin
          m_run++;
          if (m_run == STABLE) begin
            m_reported = 1;
            h = digit_of(seg1); t = digit_of(seg2); o = digit_of(seg3);
            if (h < 0 || t < 0 || o < 0) exp_err = 1;
            else begin
              exp_valid = 1;
              exp_value = 10'(h * 100 + t * 10 + o);
              exp_dp = {~seg1_dpt, ~seg2_dpt, ~seg3_dpt};
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input logic e, input logic r);
    en  = e;
    rst = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("err",   32'(err),   32'(exp_err));
    chk("value", 32'(value), 32'(exp_value));
    chk("dp",    32'(dp),    32'(exp_dp));
  endtask

  task automatic set_frame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                           input logic [2:0] d);
    seg1 = a; seg2 = b; seg3 = c;
    {seg1_dpt, seg2_dpt, seg3_dpt} = d;
  endtask

  initial begin
    bit seen;
    int hold;

    // Reset then an all-blank frame: reported as 0 on the fourth enabled edge.
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    set_frame(7'h7f, 7'h7f, 7'h7f, 3'b111);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    chk("blank_not_yet", 32'(valid), 32'd0);
    tick(1'b1, 1'b0);
    chk("blank_valid", 32'(valid), 32'd1);
    chk("blank_value", 32'(value), 32'd0);

    // "029" with tens decimal point: one report, then silence while held.
    set_frame(7'b1000000, 7'b0100100, 7'b0010000, 3'b101);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("v29_valid", 32'(valid), 32'd1);
    chk("v29_value", 32'(value), 32'd29);
    chk("v29_dp",    32'(dp),    32'b010);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    chk("v29_held_quiet", 32'(valid | err), 32'd0);

    // A change late in settling restarts the count.
    set_frame(7'b1000000, 7'b0100100, 7'b0010000, 3'b111);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    seg3 = 7'b1111000;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    chk("restart_quiet", 32'(valid), 32'd0);
    tick(1'b1, 1'b0);
    chk("v27_valid", 32'(valid), 32'd1);
    chk("v27_value", 32'(value), 32'd27);

    // Illegal tens pattern: err only, value keeps the last report.
    seg2 = 7'b1010101;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("illegal_err",   32'(err),   32'd1);
    chk("illegal_value", 32'(value), 32'd27);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);

    // "999" sampled only on every other clock.
    set_frame(7'b0010000, 7'b0010000, 7'b0010000, 3'b111);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'(i % 2 == 0), 1'b0);
      if (valid) seen = 1;
    end
    chk("v999_seen",  32'(seen),  32'd1);
    chk("v999_value", 32'(value), 32'd999);

    // Reset during settling discards the pending frame.
    set_frame(7'b1111001, 7'b0110000, 7'b0011001, 3'b011);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("mid_rst_value", 32'(value), 32'd0);
    chk("mid_rst_dp",    32'(dp),    32'd0);
    tick(1'b1, 1'b0);
    chk("post_rst_quiet", 32'(valid | err), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("post_rst_value", 32'(value), 32'd134);

    // Randomized frames, holds, enables and occasional resets against the model.
    for (int f = 0; f < 80; f++) begin
      logic [6:0] p [3];
      for (int k = 0; k < 3; k++) begin
        int r = $urandom_range(0, 19);
        if (r < 16)      p[k] = glyph[$urandom_range(0, 9)];
        else if (r < 17) p[k] = 7'b1111111;
        else             p[k] = 7'($urandom);
      end
      set_frame(p[0], p[1], p[2], 3'($urandom));
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++)
        tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_readback_decoder.md
# seg_readback_decoder

Receive-side companion to the three-digit seven-segment display path: samples the `seg1`/`seg2`/`seg3` patterns and decimal points, waits until they have been stable for a programmable number of sampled cycles, then decodes them back to a binary value with a one-cycle `valid` pulse. Illegal patterns produce an `err` pulse instead. It sits beside the display driver as a readback/self-check block and lets benches and on-board checkers recover the displayed number without probing driver internals.

## Interface
- `STABLE_CYCLES`, default 4: consecutive sampled cycles with unchanged inputs required before reporting (≥1).
- `clk` input, 1 bit: system clock, all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: sample enable (divided-clock tick); logic advances only on cycles with `en`=1.
- `seg1` input, 7 bits: hundreds digit pattern, active-low, bit0=a … bit6=g.
- `seg2` input, 7 bits: tens digit pattern, same encoding.
- `seg3` input, 7 bits: ones digit pattern, same encoding.
- `seg1_dpt`, `seg2_dpt`, `seg3_dpt` input, 1 bit each: decimal points, active-low.
- `value` output, 10 bits: decoded value, hundreds*100 + tens*10 + ones, range 0..999.
- `dp` output, 3 bits: decoded decimal points, active-high, {seg1,seg2,seg3}.
- `valid` output, 1 bit: one-cycle pulse when `value`/`dp` update.
- `err` output, 1 bit: one-cycle pulse when a stable frame contains an illegal pattern.

## Operation
- Legal patterns (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank=1111111 decodes as digit 0.
- Any other pattern is illegal.
- Frame = {seg1, seg2, seg3, three dpt bits}, 24 bits, held in the `snap` register.
- States: SETTLE (counting stability) and HOLD (frame already reported).
- On each cycle with `en`=1, rules apply in this priority order:
  - Frame ≠ `snap`: load `snap`, clear `cnt`, go to SETTLE, no pulse. A change always beats an emit in the same cycle.
  - SETTLE and `cnt` = `STABLE_CYCLES`-1:
    - All three digits legal: register `value` and `dp`, pulse `valid`.
    - Otherwise: keep `value`/`dp`, pulse `err`.
    - Go to HOLD in either case.
  - SETTLE otherwise: `cnt` increments.
  - HOLD with unchanged frame: no action. A frame is reported at most once.
- `en`=0: state, `cnt` and `snap` hold; `valid`=`err`=0 that cycle.
- Arithmetic: `value` = h*7'd100 + t*4'd10 + o, computed at 10 bits with no overflow (max 999).
- `cnt` width is clog2(`STABLE_CYCLES`), minimum 1.

## Timing
- Reset values:
  - `snap` = all ones (blank, dp off), state SETTLE, `cnt`=0.
  - `value`=0, `dp`=0, `valid`=0, `err`=0.
- After reset, an all-blank stable frame is reported as `value`=0.
- Latency: a frame first captured at enabled edge k and unchanged afterwards produces `valid`/`err` registered at enabled edge k+`STABLE_CYCLES`. It is visible in the following cycle.
- `valid` and `err` are registered and mutually exclusive. Each is high for exactly one clock.
- Reset asserted mid-SETTLE discards the pending frame. No pulse occurs in the reset cycle or the following cycle.
- `value`/`dp` change only in the cycle `valid` rises and are otherwise stable.

## Structure
- Shared package `seg7_pkg`: the ten digit pattern constants, `SEG_BLANK`, and the segment bit-order definition. The display driver uses the same package.
- One combinational sub-module `seg7_to_digit`:
  - Input: 7-bit pattern.
  - Outputs: 4-bit `digit`, `legal`, `blank`.
  - Instantiated three times.
- FSM, `snap`, `cnt` and output registers live in the top.

## Test plan
- Reset, then drive all-blank with `en`=1 → `valid` pulse 4 cycles after release, `value`=0, `dp`=0.
- Drive seg1=1000000, seg2=0100100, seg3=0010000, seg2_dpt=0 (hold) → exactly one `valid`, `value`=29, `dp`=3'b010. No further pulses while held.
- Change seg3 to 1111000 at stable count 3 of 4 → no pulse. Then `valid` 4 enabled cycles later with `value`=27.
- seg2=1010101 (illegal), held stable → one `err` pulse, `valid`=0, `value` unchanged from previous report.
- `en` toggling 1,0,1,0 with a stable frame "999" → report after 4 enabled cycles (8 clocks), `value`=999.
- Assert `rst` one cycle into SETTLE → no pulse, outputs at reset values, fresh count restarts after release.
